// File: rtl/galetron_imm_pkg.sv
// Shared immediate-field definitions for the Extender and the immediate narrower.
// Holds field widths, selection codes and the fit/truncate helper.
package galetron_imm_pkg;

    localparam int IMM_A_W = 16;
    localparam int IMM_B_W = 21;
    localparam int IMM_C_W = 18;

    localparam logic [1:0] SEL_A       = 2'b00;
    localparam logic [1:0] SEL_B       = 2'b01;
    localparam logic [1:0] SEL_C       = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    localparam logic [20:0] ILLEGAL_VALUE = 21'h000001;

    typedef struct packed {
        logic [20:0] data;
        logic        fits;
        logic        illegal;
    } narrow_entry_t;

    // Low W bits are always passed through; fits only when the bits above W are zero.
    function automatic narrow_entry_t narrow_value(input logic [31:0] word, input logic [1:0] sel);
        narrow_entry_t e;
        e.data    = 21'h000000;
        e.fits    = 1'b0;
        e.illegal = 1'b0;
        case (sel)
            SEL_A: begin
                e.data[IMM_A_W-1:0] = word[IMM_A_W-1:0];
                e.fits = (word[31:IMM_A_W] == {(32-IMM_A_W){1'b0}});
            end
            SEL_B: begin
                e.data[IMM_B_W-1:0] = word[IMM_B_W-1:0];
                e.fits = (word[31:IMM_B_W] == {(32-IMM_B_W){1'b0}});
            end
            SEL_C: begin
                e.data[IMM_C_W-1:0] = word[IMM_C_W-1:0];
                e.fits = (word[31:IMM_C_W] == {(32-IMM_C_W){1'b0}});
            end
            default: begin
                e.data    = ILLEGAL_VALUE;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/narrow_fifo2.sv
// Two-entry registered FIFO; the head register drives the outputs directly.
module narrow_fifo2 #(
    parameter int WIDTH = 23
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head_r, tail_r, head_next_s, tail_next_s;
    logic [1:0]       count_r, count_next_s;
    logic             push_s, pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_r;

    // Next-state for occupancy and storage from the push/pop pair.
    always_comb begin
        push_s       = in_valid && in_ready;
        pop_s        = out_valid && out_ready;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_next_s = in_data;
                end else begin
                    tail_next_s = in_data;
                end
                count_next_s = count_r + 2'd1;
            end
            2'b01: begin
                head_next_s  = tail_r;
                count_next_s = count_r - 2'd1;
            end
            2'b11: begin
                if (count_r == 2'd1) begin
                    head_next_s = in_data;
                end else begin
                    head_next_s = tail_r;
                    tail_next_s = in_data;
                end
            end
            default: begin
                count_next_s = count_r;
            end
        endcase
    end

    // Storage and occupancy registers; reset flushes everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= {WIDTH{1'b0}};
            tail_r  <= {WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
        end
    end

endmodule

// File: rtl/immediate_narrower.sv
// Narrows 32-bit values into 16/21/18-bit immediate fields, flags misfits,
// and counts every accepted misfit or illegal-selection entry.
module immediate_narrower
    import galetron_imm_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [1:0]             narrowSelection,
    input  logic [31:0]            inputWord,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [20:0]            narrowOutput,
    output logic                   narrowFits,
    output logic                   illegalSelection,
    output logic [COUNT_WIDTH-1:0] errorCount,
    output logic                   errorSticky,
    input  logic                   clearError
);

    narrow_entry_t          in_entry_s, out_entry_s;
    logic [22:0]            out_bits_s;
    logic                   count_event_s;
    logic [COUNT_WIDTH-1:0] err_count_r;
    logic                   err_sticky_r;

    assign in_entry_s    = narrow_value(inputWord, narrowSelection);
    assign count_event_s = inValid && inReady && !in_entry_s.fits;

    narrow_fifo2 #(.WIDTH(23)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (in_entry_s),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (out_bits_s)
    );

    assign out_entry_s      = out_bits_s;
    assign narrowOutput     = out_entry_s.data;
    assign narrowFits       = out_entry_s.fits;
    assign illegalSelection = out_entry_s.illegal;
    assign errorCount       = err_count_r;
    assign errorSticky      = err_sticky_r;

    // Saturating misfit counter; a counted event beats a simultaneous clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count_r  <= {COUNT_WIDTH{1'b0}};
            err_sticky_r <= 1'b0;
        end else if (count_event_s) begin
            err_sticky_r <= 1'b1;
            if (clearError) begin
                err_count_r <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (!(&err_count_r)) begin
                err_count_r <= err_count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                err_count_r <= err_count_r;
            end
        end else if (clearError) begin
            err_count_r  <= {COUNT_WIDTH{1'b0}};
            err_sticky_r <= 1'b0;
        end else begin
            err_count_r  <= err_count_r;
            err_sticky_r <= err_sticky_r;
        end
    end

endmodule

// File: tb/tb_immediate_narrower.sv
// Directed bench for immediate_narrower: fit rule, illegal select, buffering,
// counter saturation/clear and asynchronous flush.
module tb_immediate_narrower;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid, inReady, outValid, outReady;
    logic [1:0]  narrowSelection;
    logic [31:0] inputWord;
    logic [20:0] narrowOutput;
    logic        narrowFits, illegalSelection, errorSticky, clearError;
    logic [7:0]  errorCount;

    int checks = 0;
    int errors = 0;

    immediate_narrower #(.COUNT_WIDTH(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .inValid          (inValid),
        .inReady          (inReady),
        .narrowSelection  (narrowSelection),
        .inputWord        (inputWord),
        .outValid         (outValid),
        .outReady         (outReady),
        .narrowOutput     (narrowOutput),
        .narrowFits       (narrowFits),
        .illegalSelection (illegalSelection),
        .errorCount       (errorCount),
        .errorSticky      (errorSticky),
        .clearError       (clearError)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [1:0] s);
        inValid = 1'b1;
        inputWord = w;
        narrowSelection = s;
    endtask

    initial begin
        reset = 1'b1;
        inValid = 1'b0; outReady = 1'b0; clearError = 1'b0;
        inputWord = 32'h0; narrowSelection = 2'b00;
        #1 reset = 1'b0;
        #1;
        check("rst_inready", {31'd0, inReady}, 32'd1);
        tick(); tick();
        check("rst_outvalid", {31'd0, outValid}, 32'd0);
        check("rst_out", {11'd0, narrowOutput}, 32'd0);
        check("rst_fits", {31'd0, narrowFits}, 32'd0);
        check("rst_illegal", {31'd0, illegalSelection}, 32'd0);
        check("rst_count", {24'd0, errorCount}, 32'd0);
        check("rst_sticky", {31'd0, errorSticky}, 32'd0);
        reset = 1'b1;

        // Streaming with outReady = 1
        outReady = 1'b1;
        send(32'h0000_ABCD, 2'b00); tick();
        check("a_valid", {31'd0, outValid}, 32'd1);
        check("a_out", {11'd0, narrowOutput}, 32'h00ABCD);
        check("a_fits", {31'd0, narrowFits}, 32'd1);
        check("a_count", {24'd0, errorCount}, 32'd0);
        send(32'h0012_3456, 2'b00); tick();
        check("a_trunc_out", {11'd0, narrowOutput}, 32'h003456);
        check("a_trunc_fits", {31'd0, narrowFits}, 32'd0);
        check("a_trunc_count", {24'd0, errorCount}, 32'd1);
        check("a_trunc_sticky", {31'd0, errorSticky}, 32'd1);
        send(32'h001F_FFFF, 2'b01); tick();
        check("b_max_out", {11'd0, narrowOutput}, 32'h1FFFFF);
        check("b_max_fits", {31'd0, narrowFits}, 32'd1);
        check("b_max_inready", {31'd0, inReady}, 32'd1);
        send(32'h0020_0000, 2'b01); tick();
        check("b_over_out", {11'd0, narrowOutput}, 32'h000000);
        check("b_over_fits", {31'd0, narrowFits}, 32'd0);
        check("b_over_count", {24'd0, errorCount}, 32'd2);
        send(32'h0003_FFFF, 2'b10); tick();
        check("c_max_out", {11'd0, narrowOutput}, 32'h03FFFF);
        check("c_max_fits", {31'd0, narrowFits}, 32'd1);
        send(32'h0004_0000, 2'b10); tick();
        check("c_over_fits", {31'd0, narrowFits}, 32'd0);
        check("c_over_count", {24'd0, errorCount}, 32'd3);
        send(32'hDEAD_BEEF, 2'b11); tick();
        check("ill_out", {11'd0, narrowOutput}, 32'h000001);
        check("ill_flag", {31'd0, illegalSelection}, 32'd1);
        check("ill_fits", {31'd0, narrowFits}, 32'd0);
        check("ill_count", {24'd0, errorCount}, 32'd4);
        inValid = 1'b0; tick();
        check("drain_valid", {31'd0, outValid}, 32'd0);

        // Back-pressure: words 1, 2, 3 with outReady low
        outReady = 1'b0;
        send(32'h1, 2'b00); tick();
        check("bp1_out", {11'd0, narrowOutput}, 32'h1);
        check("bp1_inready", {31'd0, inReady}, 32'd1);
        send(32'h2, 2'b00); tick();
        check("bp2_inready", {31'd0, inReady}, 32'd0);
        check("bp2_out", {11'd0, narrowOutput}, 32'h1);
        send(32'h3, 2'b00); tick();
        check("bp3_inready", {31'd0, inReady}, 32'd0);
        check("bp3_hold_out", {11'd0, narrowOutput}, 32'h1);
        check("bp3_hold_valid", {31'd0, outValid}, 32'd1);
        outReady = 1'b1; tick();
        check("ord2_out", {11'd0, narrowOutput}, 32'h2);
        check("ord2_inready", {31'd0, inReady}, 32'd1);
        tick();
        check("ord3_out", {11'd0, narrowOutput}, 32'h3);
        check("ord3_valid", {31'd0, outValid}, 32'd1);
        inValid = 1'b0; tick();
        check("ord_empty", {31'd0, outValid}, 32'd0);

        // Saturation, then clear racing a misfit, then plain clear
        send(32'hFFFF_FFFF, 2'b00);
        repeat (260) tick();
        check("sat_count", {24'd0, errorCount}, 32'd255);
        check("sat_sticky", {31'd0, errorSticky}, 32'd1);
        clearError = 1'b1; tick();
        check("clr_race_count", {24'd0, errorCount}, 32'd1);
        check("clr_race_sticky", {31'd0, errorSticky}, 32'd1);
        inValid = 1'b0; tick();
        check("clr_count", {24'd0, errorCount}, 32'd0);
        check("clr_sticky", {31'd0, errorSticky}, 32'd0);
        clearError = 1'b0;

        // Asynchronous reset with two held entries
        outReady = 1'b0;
        send(32'h0100_0000, 2'b00); tick(); tick();
        inValid = 1'b0;
        check("pre_flush_inready", {31'd0, inReady}, 32'd0);
        check("pre_flush_count", {24'd0, errorCount}, 32'd2);
        #2 reset = 1'b0;
        #1;
        check("flush_valid", {31'd0, outValid}, 32'd0);
        check("flush_inready", {31'd0, inReady}, 32'd1);
        check("flush_count", {24'd0, errorCount}, 32'd0);
        check("flush_sticky", {31'd0, errorSticky}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_flush_valid", {31'd0, outValid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/immediate_narrower.md
# immediate_narrower

Reverse-direction partner of the Extender. It accepts 32-bit values with a field-size selection and checks that each value fits the selected immediate field (16, 21 or 18 bits, under the same zero-extension rule the Extender applies). It emits the right-aligned narrow field with a fit flag through a 2-entry output buffer. It sits on the assembler/encoder path that packs immediates into instruction words, and counts every value that does not fit.

## Interface

Parameters:
- COUNT_WIDTH, 8: width of the saturating misfit counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- inValid  input  1  input word valid.
- inReady  output  1  block can accept input; asserted when fewer than 2 entries are held.
- narrowSelection  input  2  field select: 00 = 16-bit, 01 = 21-bit, 10 = 18-bit, 11 = illegal.
- inputWord  input  32  value to narrow.
- outValid  output  1  output entry valid.
- outReady  input  1  consumer accepts the output entry.
- narrowOutput  output  21  narrowed field, right-aligned, unused upper bits 0.
- narrowFits  output  1  value fits the selected field.
- illegalSelection  output  1  entry was produced from selection 11.
- errorCount  output  COUNT_WIDTH  saturating count of accepted misfit or illegal entries.
- errorSticky  output  1  set on the first misfit or illegal entry.
- clearError  input  1  synchronous clear of errorCount and errorSticky.

## Operation

- Input handshake: a transfer occurs on a clock edge with inValid && inReady. Output handshake: a transfer occurs on a clock edge with outValid && outReady.
- Field width W: 16, 21 or 18 for selection 00, 01 or 10.
- Fit rule: narrowFits = 1 iff inputWord[31:W] == 0.
- Field value: narrowOutput = {zeros, inputWord[W-1:0]}. The low bits are passed even when the value does not fit (truncation).
- Selection 11: narrowOutput = 21'h1, narrowFits = 0, illegalSelection = 1.
- Error counting happens at input acceptance of an entry with narrowFits = 0 (including illegal entries):
  - errorCount increments and saturates at all-ones.
  - errorSticky is set.
- clearError in the same cycle as a counted entry: errorCount = 1 and errorSticky = 1 (the new event wins over the clear).
- Buffer behaviour:
  - FIFO order with 2 entries; occupancy ranges 0..2.
  - inReady = (occupancy < 2), combinational from occupancy only; it does not depend on outReady.
  - Simultaneous accept and release at full occupancy is not possible, because inReady = 0 when full.
  - Simultaneous accept and release at occupancy 1 leaves occupancy at 1.
- While outValid && !outReady, narrowOutput, narrowFits and illegalSelection hold stable.

## Timing

- Reset (asynchronous, reset low):
  - occupancy 0, outValid 0, narrowOutput 0, narrowFits 0, illegalSelection 0, errorCount 0, errorSticky 0.
  - inReady = 1 during and after reset.
- Latency: an entry accepted at edge N is visible on the outputs with outValid = 1 after edge N, i.e. in cycle N+1. The data path is fully registered; there is no combinational path from input to output.
- Throughput: 1 entry per cycle when outReady is held at 1.
- Back-pressure: with outReady = 0, two entries are accepted, then inReady drops in the cycle after the second accept. After one output release, inReady rises in the following cycle.
- Reset asserted mid-operation: the buffer is flushed immediately; held entries are lost and counters are cleared.
- errorCount and errorSticky update on the same edge as the input accept.

## Structure

- Shared package galetron_imm_pkg holds:
  - field widths IMM_A_W = 16, IMM_B_W = 21, IMM_C_W = 18;
  - selection codes SEL_A = 00, SEL_B = 01, SEL_C = 10, SEL_ILLEGAL = 11;
  - ILLEGAL_VALUE = 1.
- The Extender imports the same package.
- Sub-module narrow_fifo2: a 2-entry FIFO of width 23 (21 data bits, fit flag, illegal flag) with valid/ready on both sides. The top level holds the fit logic and the counter.

## Test plan

- Reset, then inputWord = 32'h0000_ABCD with select 00, outReady = 1 -> in the next cycle narrowOutput = 21'h00ABCD, narrowFits = 1, errorCount = 0.
- 32'h0012_3456 with select 00 -> narrowOutput = 21'h003456, narrowFits = 0, errorCount = 1, errorSticky = 1.
- 32'h001F_FFFF with select 01 -> narrowFits = 1. 32'h0020_0000 with select 01 -> narrowFits = 0, narrowOutput = 0. 32'h0003_FFFF with select 10 -> narrowFits = 1.
- Select 11 with any word -> narrowOutput = 21'h1, illegalSelection = 1, errorCount increments.
- outReady = 0 while streaming words 1, 2, 3:
  - inReady goes low after 2 accepts and word 3 is held off;
  - outputs stay stable at word 1;
  - after outReady = 1 the order is 1, 2, 3 with no loss or duplication.
- Counter saturation and reset:
  - 260 misfits -> errorCount = 255.
  - clearError together with a misfit -> errorCount = 1.
  - reset pulsed with 2 entries held -> outValid = 0, inReady = 1 immediately.
